// File: rtl/byte_bus_pkg.sv
// byte_bus_pkg: shared types for the byte bus arbiter.
// Provides BYTE_W, the arbiter state enum and the byte type.
package byte_bus_pkg;
  localparam int BYTE_W = 8;
  typedef enum logic {IDLE, BUSY} arb_state_t;
  typedef logic [BYTE_W-1:0] byte_t;
endpackage

// File: rtl/byte_bus.sv
// byte_bus: shared byte-wide bus (x = data byte, vld = byte valid).
// Modport ctrl is the driving side, mon the observing side.
interface byte_bus;
  import byte_bus_pkg::*;
  byte_t x;
  logic  vld;
  modport ctrl (output x, vld);
  modport mon  (input x, vld);
endinterface

// File: rtl/byte_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker over N requesters.
// Ports: req, excl (mask), start (first index scanned) -> valid, pick.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         excl,
  input  logic [$clog2(N)-1:0] start,
  output logic                 valid,
  output logic [$clog2(N)-1:0] pick
);
  localparam int IW = $clog2(N);

  logic [N-1:0]  elig;
  logic [IW-1:0] idx [N];

  // Position k of the rotated scan maps to (start + k) mod N.
  for (genvar k = 0; k < N; k++) begin : g_rot
    logic [IW:0] sum;
    assign sum = {1'b0, start} + (IW+1)'(k);
    assign idx[k] = (sum >= (IW+1)'(N))
                  ? IW'(sum - (IW+1)'(N))
                  : IW'(sum);
    assign elig[k] = req[idx[k]] & ~excl[idx[k]];
  end

  always_comb begin
    pick = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (elig[k]) pick = idx[k];
    end
  end

  assign valid = |elig;
endmodule

// File: rtl/byte_bus_arbiter.sv
// byte_bus_arbiter: round-robin, burst-bounded sharing of one byte_bus.
// Ports: clk, rst (async high), req[N], data[N][8] -> gnt, owner, busy, bus.
module byte_bus_arbiter
  import byte_bus_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req,
  input  logic [N-1:0][BYTE_W-1:0] data,
  output logic [N-1:0]             gnt,
  output logic [$clog2(N)-1:0]     owner,
  output logic                     busy,
  byte_bus.ctrl                    bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(MAX_BURST + 1);

  if (N < 2) begin : g_chk_n
    $error("byte_bus_arbiter: N must be >= 2");
  end
  if (MAX_BURST < 1) begin : g_chk_b
    $error("byte_bus_arbiter: MAX_BURST must be >= 1");
  end

  arb_state_t    state, state_nx;
  logic [N-1:0]  gnt_nx;
  logic [IW-1:0] owner_nx;
  logic [IW-1:0] last, last_nx;
  logic [CW-1:0] cnt, cnt_nx;

  logic          rel;
  logic          pk_valid;
  logic [IW-1:0] pk_idx;
  logic [IW-1:0] start;
  logic [N-1:0]  excl;
  logic          vld;

  function automatic logic [IW-1:0] inc(input logic [IW-1:0] i);
    return (i == IW'(N - 1)) ? '0 : i + IW'(1);
  endfunction

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .excl  (excl),
    .start (start),
    .valid (pk_valid),
    .pick  (pk_idx)
  );

  always_comb begin
    rel   = !req[owner] || (cnt == CW'(MAX_BURST));
    start = (state == BUSY) ? inc(owner) : inc(last);
    excl  = '0;
    if (state == BUSY && !req[owner]) excl[owner] = 1'b1;

    state_nx = state;
    gnt_nx   = gnt;
    owner_nx = owner;
    last_nx  = last;
    cnt_nx   = cnt;

    case (state)
      IDLE: begin
        if (pk_valid) begin
          state_nx = BUSY;
          gnt_nx   = {{(N-1){1'b0}}, 1'b1} << pk_idx;
          owner_nx = pk_idx;
          last_nx  = pk_idx;
          cnt_nx   = CW'(1);
        end
      end
      BUSY: begin
        if (!rel) begin
          cnt_nx = cnt + CW'(1);
        end else if (pk_valid) begin
          // Hand over directly; the owner is scanned last.
          gnt_nx   = {{(N-1){1'b0}}, 1'b1} << pk_idx;
          owner_nx = pk_idx;
          last_nx  = pk_idx;
          cnt_nx   = CW'(1);
        end else begin
          state_nx = IDLE;
          gnt_nx   = '0;
          owner_nx = '0;
          cnt_nx   = '0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      last  <= IW'(N - 1);
      cnt   <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      owner <= owner_nx;
      last  <= last_nx;
      cnt   <= cnt_nx;
    end
  end

  assign busy    = (state == BUSY);
  assign vld     = busy && req[owner];
  assign bus.vld = vld;
  assign bus.x   = vld ? data[owner] : '0;
endmodule

// File: tb/tb_byte_bus_arbiter.sv
// tb_byte_bus_arbiter: scoreboard bench for byte_bus_arbiter.
// Two instances: N=4/MAX_BURST=3 and N=3/MAX_BURST=1.
module tb_byte_bus_arbiter;
  import byte_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]      req0;
  logic [3:0][7:0] data0;
  logic [3:0]      gnt0;
  logic [1:0]      owner0;
  logic            busy0;

  logic [2:0]      req1;
  logic [2:0][7:0] data1;
  logic [2:0]      gnt1;
  logic [1:0]      owner1;
  logic            busy1;

  byte_bus bus0 ();
  byte_bus bus1 ();

  byte_bus_arbiter #(.N(4), .MAX_BURST(3)) dut0 (
    .clk   (clk),
    .rst   (rst),
    .req   (req0),
    .data  (data0),
    .gnt   (gnt0),
    .owner (owner0),
    .busy  (busy0),
    .bus   (bus0)
  );

  byte_bus_arbiter #(.N(3), .MAX_BURST(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .req   (req1),
    .data  (data1),
    .gnt   (gnt1),
    .owner (owner1),
    .busy  (busy1),
    .bus   (bus1)
  );

  typedef struct {
    bit         sel;
    logic [3:0] g;
    logic [1:0] o;
    logic       b;
    logic       v;
    logic [7:0] x;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (!e.sel) begin
        chk("gnt0",   {4'b0, gnt0},     {4'b0, e.g});
        chk("owner0", {6'b0, owner0},   {6'b0, e.o});
        chk("busy0",  {7'b0, busy0},    {7'b0, e.b});
        chk("vld0",   {7'b0, bus0.vld}, {7'b0, e.v});
        chk("x0",     bus0.x,           e.x);
      end else begin
        chk("gnt1",   {5'b0, gnt1},     {4'b0, e.g});
        chk("owner1", {6'b0, owner1},   {6'b0, e.o});
        chk("busy1",  {7'b0, busy1},    {7'b0, e.b});
        chk("vld1",   {7'b0, bus1.vld}, {7'b0, e.v});
        chk("x1",     bus1.x,           e.x);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("onehot",
          {7'b0, ($onehot0(gnt0) && $onehot0(gnt1))}, 8'h01);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input bit sel, input logic [3:0] r,
                     input logic [3:0] g, input logic [1:0] o,
                     input logic b, input logic v,
                     input logic [7:0] x);
    exp_t e;
    @(posedge clk);
    #1;
    if (sel) req1 = r[2:0];
    else req0 = r;
    e = '{sel, g, o, b, v, x};
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_gnt0",   {4'b0, gnt0},     8'h00);
    chk("rst_owner0", {6'b0, owner0},   8'h00);
    chk("rst_busy0",  {7'b0, busy0},    8'h00);
    chk("rst_vld0",   {7'b0, bus0.vld}, 8'h00);
    chk("rst_x0",     bus0.x,           8'h00);
    chk("rst_gnt1",   {5'b0, gnt1},     8'h00);
    chk("rst_busy1",  {7'b0, busy1},    8'h00);
    chk("rst_vld1",   {7'b0, bus1.vld}, 8'h00);
    req0 = '0;
    req1 = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] o;
    req0  = '0;
    req1  = '0;
    data0 = '0;
    data1 = '0;

    do_reset();
    data0[0] = 8'hA5;
    cyc(0, 4'b0001, 4'b0000, 0, 0, 0, 8'h00);
    cyc(0, 4'b0001, 4'b0001, 0, 1, 1, 8'hA5);
    cyc(0, 4'b0001, 4'b0001, 0, 1, 1, 8'hA5);
    cyc(0, 4'b0000, 4'b0001, 0, 1, 0, 8'h00);
    cyc(0, 4'b0000, 4'b0000, 0, 0, 0, 8'h00);

    do_reset();
    data0 = {8'h13, 8'h12, 8'h11, 8'h10};
    cyc(0, 4'b1111, 4'b0000, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 15; k++) begin
      o = 2'(((k - 1) / 3) % 4);
      cyc(0, 4'b1111, 4'b0001 << o, o, 1, 1, 8'h10 + 8'(o));
    end

    do_reset();
    data0[2] = 8'h77;
    cyc(0, 4'b0100, 4'b0000, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 4'b0100, 4'b0100, 2, 1, 1, 8'h77);
    end
    cyc(0, 4'b0000, 4'b0100, 2, 1, 0, 8'h00);
    cyc(0, 4'b0000, 4'b0000, 0, 0, 0, 8'h00);

    do_reset();
    data0 = {8'h43, 8'h32, 8'h21, 8'h10};
    cyc(0, 4'b0010, 4'b0000, 0, 0, 0, 8'h00);
    cyc(0, 4'b1010, 4'b0010, 1, 1, 1, 8'h21);
    cyc(0, 4'b1000, 4'b0010, 1, 1, 0, 8'h00);
    cyc(0, 4'b1000, 4'b1000, 3, 1, 1, 8'h43);
    cyc(0, 4'b0010, 4'b1000, 3, 1, 0, 8'h00);
    cyc(0, 4'b0010, 4'b0010, 1, 1, 1, 8'h21);
    cyc(0, 4'b0000, 4'b0010, 1, 1, 0, 8'h00);
    cyc(0, 4'b0000, 4'b0000, 0, 0, 0, 8'h00);

    do_reset();
    cyc(0, 4'b0100, 4'b0000, 0, 0, 0, 8'h00);
    cyc(0, 4'b0100, 4'b0100, 2, 1, 1, 8'h32);
    do_reset();
    cyc(0, 4'b1100, 4'b0000, 0, 0, 0, 8'h00);
    cyc(0, 4'b1100, 4'b0100, 2, 1, 1, 8'h32);
    cyc(0, 4'b1100, 4'b0100, 2, 1, 1, 8'h32);

    do_reset();
    data1 = {8'hA2, 8'hA1, 8'hA0};
    cyc(1, 4'b0111, 4'b0000, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      o = 2'((k - 1) % 3);
      cyc(1, 4'b0111, 4'b0001 << o, o, 1, 1, 8'hA0 + 8'(o));
    end
    cyc(1, 4'b0000, 4'b0100, 2, 1, 0, 8'h00);
    cyc(1, 4'b0000, 4'b0000, 0, 0, 0, 8'h00);

    repeat (3) @(posedge clk);
    chk("sb_drain", 8'(sb.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
